// File: rtl/traffic_light_monitor_pkg.sv
// Shared phase encoding, legal-successor rule and default phase lengths
// used by the traffic-light controller and its monitor.
package traffic_pkg;

  localparam logic [1:0] PH_NONE  = 2'd0;
  localparam logic [1:0] PH_RED   = 2'd1;
  localparam logic [1:0] PH_GREEN = 2'd2;
  localparam logic [1:0] PH_AMBER = 2'd3;

  localparam int DEF_RED_TICS   = 35;
  localparam int DEF_GREEN_TICS = 20;
  localparam int DEF_AMBER_TICS = 3;
  localparam int DEF_TOL        = 0;

  typedef enum logic [1:0] {
    LAMP_DARK,
    LAMP_ONE,
    LAMP_MULTI
  } lamp_kind_e;

  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    case (ph)
      PH_RED:   return PH_GREEN;
      PH_GREEN: return PH_AMBER;
      PH_AMBER: return PH_RED;
      default:  return PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp inputs and status outputs of the monitor; master drives the lamps,
// slave is the monitor itself.
interface traffic_light_monitor_if #(
  parameter int ERR_W = 16
) ();

  logic             red;
  logic             amber;
  logic             green;
  logic             sync_ok;
  logic [1:0]       phase;
  logic             err_illegal;
  logic             err_order;
  logic             err_duration;
  logic [ERR_W-1:0] err_count;

  modport master (
    output red, amber, green,
    input  sync_ok, phase, err_illegal, err_order, err_duration, err_count
  );

  modport slave (
    input  red, amber, green,
    output sync_ok, phase, err_illegal, err_order, err_duration, err_count
  );

endinterface

// File: rtl/traffic_phase_timer.sv
// Times the current phase: saturating sample counter plus a sticky flag
// so an overlong phase is reported only once.
module traffic_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_restart,
  input  logic             i_hold,
  input  logic [CNT_W-1:0] i_exp,
  input  logic [CNT_W-1:0] i_tol,
  output logic             o_too_long_pulse,
  output logic             o_too_short,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_too_long;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W+1:0] w_limit;
  logic [CNT_W-1:0] w_lo;

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_limit   = {2'b00, i_exp} + {2'b00, i_tol} + {{(CNT_W+1){1'b0}}, 1'b1};
  assign w_lo      = (i_tol >= i_exp) ? CNT_W'(1) : i_exp - i_tol;

  // Too-long means "one more sample of this phase would cross the limit".
  assign o_too_long_pulse = !r_too_long && ({2'b00, w_cnt_inc} >= w_limit);
  assign o_too_short      = !r_too_long && (r_cnt < w_lo);
  assign o_cnt            = r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_too_long <= 1'b0;
    end else if (i_restart) begin
      r_cnt      <= CNT_W'(1);
      r_too_long <= 1'b0;
    end else if (i_hold) begin
      r_cnt <= w_cnt_inc;
      if (o_too_long_pulse) r_too_long <= 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive watchdog on a traffic-light controller: locks onto RED->GREEN->AMBER
// and reports illegal lamps, out-of-order phases and bad phase lengths.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int RED_TICS   = DEF_RED_TICS,
  parameter int GREEN_TICS = DEF_GREEN_TICS,
  parameter int AMBER_TICS = DEF_AMBER_TICS,
  parameter int TOL        = DEF_TOL,
  parameter int CNT_W      = 8,
  parameter int ERR_W      = 16
) (
  input logic                  clock,
  input logic                  reset_n,
  traffic_light_monitor_if.slave bus
);

  localparam logic [0:0] ST_UNSYNC = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [0:0]       r_state;
  logic [1:0]       r_phase;
  logic             r_err_ill;
  logic             r_err_ord;
  logic             r_err_dur;
  logic [ERR_W-1:0] r_err_cnt;

  logic [2:0]       w_lamps;
  lamp_kind_e       w_kind;
  logic [1:0]       w_light;
  logic [0:0]       w_state_nxt;
  logic [1:0]       w_phase_nxt;
  logic             w_restart;
  logic             w_hold;
  logic             w_ill;
  logic             w_ord;
  logic             w_dur;
  logic [CNT_W-1:0] w_exp;
  logic             w_too_long;
  logic             w_too_short;
  logic [CNT_W-1:0] w_cnt;

  assign w_lamps = {bus.red, bus.amber, bus.green};

  always_comb begin
    w_kind  = LAMP_MULTI;
    w_light = PH_NONE;
    case (w_lamps)
      3'b000:  w_kind = LAMP_DARK;
      3'b100:  begin w_kind = LAMP_ONE; w_light = PH_RED;   end
      3'b001:  begin w_kind = LAMP_ONE; w_light = PH_GREEN; end
      3'b010:  begin w_kind = LAMP_ONE; w_light = PH_AMBER; end
      default: ;
    endcase
  end

  always_comb begin
    case (r_phase)
      PH_RED:   w_exp = CNT_W'(RED_TICS);
      PH_GREEN: w_exp = CNT_W'(GREEN_TICS);
      PH_AMBER: w_exp = CNT_W'(AMBER_TICS);
      default:  w_exp = '0;
    endcase
  end

  // Branches are mutually exclusive, which gives the illegal > order > duration priority.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_restart   = 1'b0;
    w_hold      = 1'b0;
    w_ill       = 1'b0;
    w_ord       = 1'b0;
    w_dur       = 1'b0;
    if (r_state == ST_UNSYNC) begin
      if (w_kind == LAMP_ONE) begin
        w_phase_nxt = w_light;
        if (w_light == next_phase(r_phase)) begin
          w_state_nxt = ST_LOCKED;
          w_restart   = 1'b1;
        end
      end
    end else if (w_kind != LAMP_ONE) begin
      w_ill       = 1'b1;
      w_state_nxt = ST_UNSYNC;
      w_phase_nxt = PH_NONE;
    end else if (w_light == r_phase) begin
      w_hold = 1'b1;
      w_dur  = w_too_long;
    end else if (w_light == next_phase(r_phase)) begin
      w_dur       = w_too_short;
      w_restart   = 1'b1;
      w_phase_nxt = w_light;
    end else begin
      w_ord       = 1'b1;
      w_state_nxt = ST_UNSYNC;
      w_phase_nxt = w_light;
    end
  end

  traffic_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock            (clock),
    .reset_n          (reset_n),
    .i_restart        (w_restart),
    .i_hold           (w_hold),
    .i_exp            (w_exp),
    .i_tol            (CNT_W'(TOL)),
    .o_too_long_pulse (w_too_long),
    .o_too_short      (w_too_short),
    .o_cnt            (w_cnt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_UNSYNC;
      r_phase   <= PH_NONE;
      r_err_ill <= 1'b0;
      r_err_ord <= 1'b0;
      r_err_dur <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_err_ill <= w_ill;
      r_err_ord <= w_ord;
      r_err_dur <= w_dur;
      if ((w_ill || w_ord || w_dur) && (r_err_cnt != ERR_MAX))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  // A locked phase is always being timed, so its count can never be zero.
  a_cnt_live: assert property (@(posedge clock) disable iff (!reset_n)
                               (r_state == ST_LOCKED) |-> (w_cnt != '0));

  assign bus.sync_ok      = (r_state == ST_LOCKED);
  assign bus.phase        = r_phase;
  assign bus.err_illegal  = r_err_ill;
  assign bus.err_order    = r_err_ord;
  assign bus.err_duration = r_err_dur;
  assign bus.err_count    = r_err_cnt;

endmodule
